// File: rtl/conv_out_pkg.sv
// Shared definitions for the convolution output path: default bus widths used by the
// address queue, the output memory and the write sequencer, plus the sequencer state type.
package conv_out_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    DATA  = 3'd3,
    WRITE = 3'd4
  } state_e;

endpackage

// File: rtl/output_write_sequencer_if.sv
// Bundle of the address-queue, result-stream and memory-write signals around the sequencer.
// The master side is the sequencer; the slave side is the queue/MAC/memory environment.
interface output_write_sequencer_if #(
  parameter int ADDR_WIDTH = conv_out_pkg::DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = conv_out_pkg::DEFAULT_DATA_WIDTH
) ();

  logic                  q_empty;
  logic                  q_pop;
  logic [ADDR_WIDTH-1:0] q_addr;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;

  modport master (
    input  q_empty, q_addr, res_valid, res_data, mem_ack,
    output q_pop, res_ready, mem_wr_en, mem_addr, mem_wdata
  );

  modport slave (
    output q_empty, q_addr, res_valid, res_data, mem_ack,
    input  q_pop, res_ready, mem_wr_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/output_write_sequencer.sv
// Pops one output address, pairs it with the next MAC result and issues one acknowledged
// write to the output feature-map memory; counts completed writes.
module output_write_sequencer
  import conv_out_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  output_write_sequencer_if.master bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] wr_count
);

  state_e                state;
  state_e                state_next;
  logic                  q_pop_r;
  logic                  res_ready_r;
  logic                  mem_wr_en_r;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!bus.q_empty) state_next = POP;
      POP:     state_next = LATCH;
      LATCH:   state_next = DATA;
      DATA:    if (bus.res_valid) state_next = WRITE;
      WRITE:   if (bus.mem_ack) state_next = bus.q_empty ? IDLE : POP;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are pure state decodes
  // with no input-to-output combinational path.
  // NOTE: all sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_pop_r     <= 1'b0;
      res_ready_r <= 1'b0;
      mem_wr_en_r <= 1'b0;
      busy        <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      wr_count    <= '0;
    end else begin
      state       <= state_next;
      q_pop_r     <= (state_next == POP);
      res_ready_r <= (state_next == DATA);
      mem_wr_en_r <= (state_next == WRITE);
      busy        <= (state_next != IDLE);
      if (state == LATCH) addr_reg <= bus.q_addr;
      if (state == DATA && bus.res_valid) data_reg <= bus.res_data;
      if (state == WRITE && bus.mem_ack) wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

  assign bus.q_pop     = q_pop_r;
  assign bus.res_ready = res_ready_r;
  assign bus.mem_wr_en = mem_wr_en_r;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = data_reg;

endmodule
